// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronises and glitch-filters the lines,
// deserialises 11-bit frames, checks start/parity/stop and keeps a two-byte history.
module ps2_frame_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        oflag,
    output logic        frame_err,
    output logic        busy
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT + 1);
    // The watchdog clears on the edge after the fall cycle, so expiring here puts
    // frame_err exactly TIMEOUT cycles after the last fall strobe.
    localparam int EXPIRE_AT = TIMEOUT - 2;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    function automatic logic frame_ok(input logic [7:0] data, input logic par,
                                      input logic stop);
        return (^{data, par}) & stop;
    endfunction

    logic           clk_meta_r;
    logic           clk_sync_r;
    logic           data_meta_r;
    logic           data_sync_r;
    logic           fclk_r;
    logic           fclk_d_r;
    logic [FCW-1:0] fcnt_r;
    logic           fall_s;

    state_t         state_r;
    state_t         state_s;
    logic [3:0]     bitcnt_r;
    logic [3:0]     bitcnt_s;
    logic [7:0]     shift_r;
    logic [7:0]     shift_s;
    logic           parity_r;
    logic           parity_s;
    logic [WDW-1:0] wd_r;
    logic [WDW-1:0] wd_s;
    logic [15:0]    keycode_r;
    logic [15:0]    keycode_s;
    logic           oflag_r;
    logic           oflag_s;
    logic           ferr_r;
    logic           ferr_s;
    logic           busy_r;
    logic           busy_s;

    // Line synchronisers and the ps2_clk level filter
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
            fclk_r      <= 1'b1;
            fclk_d_r    <= 1'b1;
            fcnt_r      <= FCW'(0);
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
            fclk_d_r    <= fclk_r;
            if (clk_sync_r == fclk_r) begin
                fcnt_r <= FCW'(0);
            end else if (fcnt_r == FCW'(FILTER_LEN - 1)) begin
                fclk_r <= ~fclk_r;
                fcnt_r <= FCW'(0);
            end else begin
                fcnt_r <= fcnt_r + FCW'(1);
            end
        end
    end

    assign fall_s = fclk_d_r & ~fclk_r;

    // Frame FSM next-state and output decode
    always_comb begin
        state_s   = state_r;
        bitcnt_s  = bitcnt_r;
        shift_s   = shift_r;
        parity_s  = parity_r;
        wd_s      = wd_r;
        keycode_s = keycode_r;
        oflag_s   = 1'b0;
        ferr_s    = 1'b0;
        case (state_r)
            IDLE: begin
                wd_s = WDW'(0);
                if (fall_s && !data_sync_r) begin
                    state_s  = RECV;
                    bitcnt_s = 4'd1;
                    shift_s  = 8'h00;
                end else begin
                    state_s = IDLE;
                end
            end
            RECV: begin
                if (fall_s) begin
                    wd_s     = WDW'(0);
                    bitcnt_s = bitcnt_r + 4'd1;
                    if (bitcnt_r <= 4'd8) begin
                        shift_s = {data_sync_r, shift_r[7:1]};
                    end else if (bitcnt_r == 4'd9) begin
                        parity_s = data_sync_r;
                    end else begin
                        state_s  = IDLE;
                        bitcnt_s = 4'd0;
                        if (frame_ok(shift_r, parity_r, data_sync_r)) begin
                            keycode_s = {keycode_r[7:0], shift_r};
                            oflag_s   = 1'b1;
                        end else begin
                            ferr_s = 1'b1;
                        end
                    end
                end else if (wd_r == WDW'(EXPIRE_AT)) begin
                    state_s  = IDLE;
                    bitcnt_s = 4'd0;
                    wd_s     = WDW'(0);
                    ferr_s   = 1'b1;
                end else begin
                    wd_s = wd_r + WDW'(1);
                end
            end
            default: begin
                state_s  = IDLE;
                bitcnt_s = 4'd0;
                wd_s     = WDW'(0);
            end
        endcase
        busy_s = (state_s == RECV);
    end

    // Frame FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            bitcnt_r  <= 4'd0;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
            wd_r      <= WDW'(0);
            keycode_r <= 16'h0000;
            oflag_r   <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            bitcnt_r  <= bitcnt_s;
            shift_r   <= shift_s;
            parity_r  <= parity_s;
            wd_r      <= wd_s;
            keycode_r <= keycode_s;
            oflag_r   <= oflag_s;
            ferr_r    <= ferr_s;
            busy_r    <= busy_s;
        end
    end

    assign keycode   = keycode_r;
    assign oflag     = oflag_r;
    assign frame_err = ferr_r;
    assign busy      = busy_r;

endmodule
